// File: rtl/ram_loader_pkg.sv
// rtl/ram_loader_pkg.sv - shared types and constants for the SAP-1 RAM loader
package ram_loader_pkg;

    localparam int CKSUM_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        W_WAIT,
        W_SETUP,
        W_STROBE,
        W_HOLD,
        R_ADDR,
        R_SAMPLE,
        FINISH
    } state_t;

endpackage

// File: rtl/ram_loader.sv
// rtl/ram_loader.sv - streams 16 nibbles into the SAP-1 RAM and optionally verifies them by checksum
module ram_loader
    import ram_loader_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4,
    parameter int VERIFY = 1
) (
    input  logic               CLK,
    input  logic               CLR,
    input  logic               START,
    input  logic               IN_VALID,
    output logic               IN_READY,
    input  logic [DATA_W-1:0]  IN_DATA,
    output logic               CE_N,
    output logic               WE_N,
    output logic [ADDR_W-1:0]  A,
    output logic [DATA_W-1:0]  D,
    input  logic [DATA_W-1:0]  S,
    output logic               BUSY,
    output logic               DONE,
    output logic               ERR,
    output logic [CKSUM_W-1:0] CHECKSUM
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    state_t              state;
    logic [ADDR_W-1:0]   addr;
    logic [CKSUM_W-1:0]  wr_sum;
    logic [CKSUM_W-1:0]  rd_sum;
    logic [CKSUM_W-1:0]  in_ext;
    logic [CKSUM_W-1:0]  rd_next;

    assign in_ext   = {{(CKSUM_W-DATA_W){1'b0}}, IN_DATA};
    assign rd_next  = rd_sum + {{(CKSUM_W-DATA_W){1'b0}}, S};
    assign CHECKSUM = wr_sum;

    // Every RAM-facing output is loaded with the value of the state being entered,
    // so A/D only ever move on edges where WE_N is (and stays) high.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state    <= IDLE;
            addr     <= '0;
            wr_sum   <= '0;
            rd_sum   <= '0;
            CE_N     <= 1'b1;
            WE_N     <= 1'b1;
            A        <= '0;
            D        <= '0;
            IN_READY <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            ERR      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (START) begin
                        addr     <= '0;
                        wr_sum   <= '0;
                        rd_sum   <= '0;
                        ERR      <= 1'b0;
                        IN_READY <= 1'b1;
                        BUSY     <= 1'b1;
                        state    <= W_WAIT;
                    end
                end
                W_WAIT: begin
                    if (IN_VALID) begin
                        D        <= IN_DATA;
                        A        <= addr;
                        wr_sum   <= wr_sum + in_ext;
                        IN_READY <= 1'b0;
                        state    <= W_SETUP;
                    end
                end
                W_SETUP: begin
                    CE_N  <= 1'b0;
                    WE_N  <= 1'b0;
                    state <= W_STROBE;
                end
                W_STROBE: begin
                    CE_N  <= 1'b1;
                    WE_N  <= 1'b1;
                    state <= W_HOLD;
                end
                W_HOLD: begin
                    if (addr == LAST_ADDR) begin
                        if (VERIFY != 0) begin
                            addr  <= '0;
                            A     <= '0;
                            CE_N  <= 1'b0;
                            state <= R_ADDR;
                        end else begin
                            DONE  <= 1'b1;
                            state <= FINISH;
                        end
                    end else begin
                        addr     <= addr + 1'b1;
                        IN_READY <= 1'b1;
                        state    <= W_WAIT;
                    end
                end
                R_ADDR: begin
                    state <= R_SAMPLE;
                end
                R_SAMPLE: begin
                    rd_sum <= rd_next;
                    if (addr == LAST_ADDR) begin
                        ERR   <= (rd_next != wr_sum);
                        CE_N  <= 1'b1;
                        DONE  <= 1'b1;
                        state <= FINISH;
                    end else begin
                        addr  <= addr + 1'b1;
                        A     <= addr + 1'b1;
                        state <= R_ADDR;
                    end
                end
                FINISH: begin
                    DONE  <= 1'b0;
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_loader.sv
// tb/tb_ram_loader.sv - scoreboard bench for ram_loader with a behavioural 16x4 RAM
module tb_ram_loader;

    logic       CLK = 1'b0;
    logic       CLR;
    logic       START;
    logic       IN_VALID;
    logic [3:0] IN_DATA;

    logic       in_ready1, ce_n1, we_n1, busy1, done1, err1;
    logic [3:0] a1, d1, s1;
    logic [7:0] checksum1;

    logic       in_ready2, ce_n2, we_n2, busy2, done2, err2;
    logic [3:0] a2, d2;
    logic [7:0] checksum2;

    logic       force_s7;
    logic [3:0] ram [16];
    logic [3:0] stim [16];
    logic [7:0] exp_q [$];

    int n_checks = 0;
    int n_fail   = 0;

    logic       prev_we = 1'b1;
    logic [3:0] prev_a = '0, prev_d = '0;
    logic       hold_pending = 1'b0;
    logic [7:0] strobe_ad = '0;
    int         pulses = 0;
    int         bad_read2 = 0;

    always #5 CLK = ~CLK;

    ram_loader #(.ADDR_W(4), .DATA_W(4), .VERIFY(1)) u_dut (
        .CLK(CLK), .CLR(CLR), .START(START), .IN_VALID(IN_VALID), .IN_READY(in_ready1),
        .IN_DATA(IN_DATA), .CE_N(ce_n1), .WE_N(we_n1), .A(a1), .D(d1), .S(s1),
        .BUSY(busy1), .DONE(done1), .ERR(err1), .CHECKSUM(checksum1)
    );

    ram_loader #(.ADDR_W(4), .DATA_W(4), .VERIFY(0)) u_dut_nv (
        .CLK(CLK), .CLR(CLR), .START(START), .IN_VALID(IN_VALID), .IN_READY(in_ready2),
        .IN_DATA(IN_DATA), .CE_N(ce_n2), .WE_N(we_n2), .A(a2), .D(d2), .S(4'h0),
        .BUSY(busy2), .DONE(done2), .ERR(err2), .CHECKSUM(checksum2)
    );

    always @(posedge CLK) if (!ce_n1 && !we_n1) ram[a1] <= d1;
    assign s1 = (force_s7 && a1 == 4'd7) ? 4'h0 : ram[a1];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Write-strobe monitor: pulse width, A/D stability and scoreboard pop on each WE_N pulse.
    always @(negedge CLK) begin
        if (!we_n1) begin
            chk("we_single_cycle", 32'(prev_we), 32'd1);
            chk("ad_setup_stable", 32'({prev_a, prev_d}), 32'({a1, d1}));
            chk("ce_with_we", 32'(ce_n1), 32'd0);
            chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                chk("wr_addr_data", 32'({a1, d1}), 32'(exp_q[0]));
                void'(exp_q.pop_front());
            end
            pulses       <= pulses + 1;
            hold_pending <= 1'b1;
            strobe_ad    <= {a1, d1};
        end else if (hold_pending) begin
            if (busy1) chk("ad_hold_stable", 32'({a1, d1}), 32'(strobe_ad));
            hold_pending <= 1'b0;
        end
        if (!ce_n2 && we_n2) bad_read2 <= bad_read2 + 1;
        prev_we <= we_n1;
        prev_a  <= a1;
        prev_d  <= d1;
    end

    function automatic logic [7:0] stim_sum();
        logic [7:0] s = '0;
        for (int i = 0; i < 16; i++) s = s + {4'h0, stim[i]};
        return s;
    endfunction

    task automatic do_load(input int gap_at, input int gap_len, input int clr_addr, input logic force7);
        int idx, cnt, done2_cnt, gapped, since_take, p0, r0;
        logic take;
        logic exp_err;
        force_s7 = force7;
        @(negedge CLK);
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back({i[3:0], stim[i]});
        p0 = pulses;
        r0 = bad_read2;
        START = 1'b1;
        IN_VALID = 1'b1;
        IN_DATA = stim[0];
        @(posedge CLK);
        #1;
        START = 1'b0;
        chk("busy_after_start", 32'(busy1), 32'd1);
        chk("err_clear_on_start", 32'(err1), 32'd0);
        idx = 0; cnt = 0; done2_cnt = -1; gapped = 0; since_take = 3;
        while (!done1 && cnt < 400) begin
            @(negedge CLK);
            if (clr_addr >= 0 && a1 == clr_addr[3:0] && !we_n1) begin
                CLR = 1'b1;
                @(posedge CLK);
                #1;
                CLR = 1'b0;
                chk("clr_ce_n", 32'(ce_n1), 32'd1);
                chk("clr_we_n", 32'(we_n1), 32'd1);
                chk("clr_busy", 32'(busy1), 32'd0);
                chk("clr_checksum", 32'(checksum1), 32'd0);
                chk("clr_in_ready", 32'(in_ready1), 32'd0);
                chk("clr_a_d", 32'({a1, d1}), 32'd0);
                exp_q.delete();
                return;
            end
            if (idx < 16) IN_DATA = stim[idx];
            if (idx == gap_at && since_take >= 3 && gapped < gap_len) begin
                IN_VALID = 1'b0;
                gapped++;
                chk("gap_in_ready", 32'(in_ready1), 32'd1);
                chk("gap_no_we", 32'(we_n1), 32'd1);
            end else begin
                IN_VALID = 1'b1;
            end
            take = IN_VALID && in_ready1;
            @(posedge CLK);
            cnt++;
            since_take++;
            if (take) begin
                idx++;
                since_take = 0;
            end
            #1;
            if (done2 && done2_cnt < 0) done2_cnt = cnt;
        end
        exp_err = force7 && (stim[7] != 4'h0);
        chk("done_latency_verify", 32'(cnt), 32'(96 + gap_len));
        chk("done_latency_noverify", 32'(done2_cnt), 32'(64 + gap_len));
        chk("checksum", 32'(checksum1), 32'(stim_sum()));
        chk("checksum_nv", 32'(checksum2), 32'(stim_sum()));
        chk("err_in_finish", 32'(err1), 32'(exp_err));
        chk("we_pulse_count", 32'(pulses - p0), 32'd16);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        chk("nv_no_read_cycle", 32'(bad_read2 - r0), 32'd0);
        for (int i = 0; i < 16; i++) chk("ram_content", 32'(ram[i]), 32'(stim[i]));
        repeat (2) @(negedge CLK);
        chk("done_one_cycle", 32'(done1), 32'd0);
        chk("idle_busy", 32'(busy1), 32'd0);
        chk("err_held_idle", 32'(err1), 32'(exp_err));
        chk("checksum_held_idle", 32'(checksum1), 32'(stim_sum()));
    endtask

    initial begin
        CLR = 1'b1; START = 1'b0; IN_VALID = 1'b0; IN_DATA = '0; force_s7 = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        START = 1'b1;
        @(posedge CLK);
        #1;
        chk("start_during_clr_busy", 32'(busy1), 32'd0);
        chk("start_during_clr_ready", 32'(in_ready1), 32'd0);
        @(negedge CLK);
        CLR = 1'b0; START = 1'b0;
        chk("rst_ce_n", 32'(ce_n1), 32'd1);
        chk("rst_we_n", 32'(we_n1), 32'd1);
        chk("rst_a_d", 32'({a1, d1}), 32'd0);
        chk("rst_done_err", 32'({done1, err1}), 32'd0);
        chk("rst_checksum", 32'(checksum1), 32'd0);
        chk("rst_nv_busy", 32'(busy2), 32'd0);

        for (int i = 0; i < 16; i++) stim[i] = 4'(i);
        do_load(-1, 0, -1, 1'b0);
        chk("checksum_ramp", 32'(checksum1), 32'h78);

        do_load(5, 3, -1, 1'b0);

        do_load(-1, 0, -1, 1'b1);
        for (int i = 0; i < 16; i++) stim[i] = 4'($urandom_range(0, 15));
        do_load(-1, 0, -1, 1'b0);

        for (int i = 0; i < 16; i++) stim[i] = 4'($urandom_range(0, 15));
        do_load(-1, 0, 9, 1'b0);
        for (int i = 0; i < 16; i++) stim[i] = ~stim[i];
        do_load(-1, 0, -1, 1'b0);

        for (int i = 0; i < 16; i++) stim[i] = 4'hF;
        do_load(-1, 0, -1, 1'b0);
        chk("checksum_all_f", 32'(checksum2), 32'hF0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
